// File: rtl/bus_cmd_frontend.sv
// bus_cmd_frontend: operator front-end for the system bus.
// Debounces N_MASTERS trigger buttons plus a load button. In config mode a
// load press captures switch_array into an indexed field bank; in run mode a
// trigger press runs a per-master start handshake with busy timeout.
// Handshake: m_start pulses one cycle; the master answers by raising m_busy
// within BUSY_TIMEOUT cycles and lowering it when done. A busy that is
// already high at press time is waited out before m_start is issued.
module bus_cmd_frontend #(
  parameter int N_MASTERS       = 2,
  parameter int SW_WIDTH        = 12,
  parameter int N_FIELDS        = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int BUSY_TIMEOUT    = 16,
  localparam int IDX_W          = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1
) (
  input  logic                          clock,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [N_MASTERS-1:0]          btn_raw,
  input  logic                          load_btn_raw,
  input  logic                          mode_switch,
  input  logic [N_MASTERS-1:0]          rw_switch,
  input  logic [SW_WIDTH-1:0]           switch_array,
  input  logic [N_MASTERS-1:0]          m_busy,
  output logic [N_MASTERS-1:0]          m_start,
  output logic [N_MASTERS-1:0]          m_rw,
  output logic [N_MASTERS-1:0]          cmd_pending,
  output logic [N_MASTERS-1:0]          cmd_error,
  output logic [N_FIELDS*SW_WIDTH-1:0]  field_data,
  output logic [IDX_W-1:0]              field_idx,
  output logic [3*N_MASTERS-1:0]        o_dbg_state
);

  // Button inputs: bits [N_MASTERS-1:0] are triggers, bit N_MASTERS is load.
  localparam int N_IN = N_MASTERS + 1;
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TO_W = $clog2(BUSY_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PENDING = 3'd1,
    S_START   = 3'd2,
    S_ACK     = 3'd3,
    S_ACTIVE  = 3'd4
  } state_t;

  logic [N_IN-1:0]     w_raw;
  logic [N_IN-1:0]     r_sync1;
  logic [N_IN-1:0]     r_sync2;
  logic [N_IN-1:0]     r_db;
  logic [N_IN-1:0]     r_press;
  logic [N_IN-1:0]     r_armed;
  logic [DB_W-1:0]     r_db_cnt [N_IN];
  logic [1:0]          r_settle;
  logic                w_settled;
  logic                w_load_press;

  logic [SW_WIDTH-1:0] r_field [N_FIELDS];
  logic [IDX_W-1:0]    r_field_idx;

  state_t              r_state  [N_MASTERS];
  logic [TO_W-1:0]     r_to_cnt [N_MASTERS];
  logic [N_MASTERS-1:0] r_start;
  logic [N_MASTERS-1:0] r_rw;
  logic [N_MASTERS-1:0] r_pending;
  logic [N_MASTERS-1:0] r_err;

  assign w_raw        = {load_btn_raw, btn_raw};
  assign w_settled    = (r_settle == 2'd2);
  assign w_load_press = r_press[N_MASTERS];

  // Two-flop synchroniser; reset value is "released".
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Marks when the synchroniser holds real pin values again after reset.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) r_settle <= 2'd0;
    else if (!w_settled) r_settle <= r_settle + 2'd1;
  end

  // Debouncer with press pulse; a button held through reset must be released
  // once (armed) before its next press produces an event.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_db    <= '1;
      r_press <= '0;
      r_armed <= '0;
      for (int k = 0; k < N_IN; k++) r_db_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < N_IN; k++) begin
        r_press[k] <= 1'b0;
        if (w_settled && r_sync2[k]) r_armed[k] <= 1'b1;
        if (r_sync2[k] == r_db[k]) begin
          r_db_cnt[k] <= '0;
        end else if (r_db_cnt[k] == DB_W'(DEBOUNCE_CYCLES)) begin
          r_db[k]     <= r_sync2[k];
          r_db_cnt[k] <= '0;
          r_press[k]  <= ~r_sync2[k] & r_armed[k];
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
        end
      end
    end
  end

  // Field bank: config-mode load press stores switch_array and advances index.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_field_idx <= '0;
      for (int k = 0; k < N_FIELDS; k++) r_field[k] <= '0;
    end else if (w_load_press && !mode_switch && enable) begin
      r_field[r_field_idx] <= switch_array;
      r_field_idx <= (r_field_idx == IDX_W'(N_FIELDS - 1)) ? '0 : r_field_idx + 1'b1;
    end
  end

  // Per-master start handshake FSMs with registered outputs.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_start   <= '0;
      r_rw      <= '0;
      r_pending <= '0;
      r_err     <= '0;
      for (int i = 0; i < N_MASTERS; i++) begin
        r_state[i]  <= S_IDLE;
        r_to_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_MASTERS; i++) begin
        r_start[i] <= 1'b0;
        case (r_state[i])
          S_IDLE: begin
            if (r_press[i] && mode_switch && enable) begin
              r_rw[i]      <= rw_switch[i];
              r_err[i]     <= 1'b0;
              r_pending[i] <= 1'b1;
              if (!m_busy[i]) begin
                r_state[i] <= S_START;
                r_start[i] <= 1'b1;
              end else begin
                r_state[i] <= S_PENDING;
              end
            end
          end
          S_PENDING: begin
            if (!m_busy[i]) begin
              r_state[i] <= S_START;
              r_start[i] <= 1'b1;
            end
          end
          S_START: begin
            r_state[i]  <= S_ACK;
            r_to_cnt[i] <= TO_W'(BUSY_TIMEOUT - 1);
          end
          S_ACK: begin
            if (m_busy[i]) begin
              r_state[i] <= S_ACTIVE;
            end else if (r_to_cnt[i] == '0) begin
              r_err[i]     <= 1'b1;
              r_pending[i] <= 1'b0;
              r_state[i]   <= S_IDLE;
            end else begin
              r_to_cnt[i] <= r_to_cnt[i] - 1'b1;
            end
          end
          S_ACTIVE: begin
            if (!m_busy[i]) begin
              r_pending[i] <= 1'b0;
              r_state[i]   <= S_IDLE;
            end
          end
          default: begin
            r_pending[i] <= 1'b0;
            r_state[i]   <= S_IDLE;
          end
        endcase
      end
    end
  end

  for (genvar k = 0; k < N_FIELDS; k++) begin : g_field
    assign field_data[k*SW_WIDTH +: SW_WIDTH] = r_field[k];
  end

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_dbg
    assign o_dbg_state[3*i +: 3] = r_state[i];
  end

  assign m_start     = r_start;
  assign m_rw        = r_rw;
  assign cmd_pending = r_pending;
  assign cmd_error   = r_err;
  assign field_idx   = r_field_idx;

endmodule

// File: tb/tb_bus_cmd_frontend.sv
// Directed testbench for bus_cmd_frontend (default parameters).
module tb_bus_cmd_frontend;

  logic        clock = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  btn_raw;
  logic        load_btn_raw;
  logic        mode_switch;
  logic [1:0]  rw_switch;
  logic [11:0] switch_array;
  logic [1:0]  m_busy;
  logic [1:0]  m_start;
  logic [1:0]  m_rw;
  logic [1:0]  cmd_pending;
  logic [1:0]  cmd_error;
  logic [47:0] field_data;
  logic [1:0]  field_idx;
  logic [5:0]  o_dbg_state;

  int errors = 0;
  int checks = 0;
  int start_cnt0 = 0;
  int start_cnt1 = 0;
  int base;

  bus_cmd_frontend dut (
    .clock(clock), .rst(rst), .enable(enable), .btn_raw(btn_raw),
    .load_btn_raw(load_btn_raw), .mode_switch(mode_switch),
    .rw_switch(rw_switch), .switch_array(switch_array), .m_busy(m_busy),
    .m_start(m_start), .m_rw(m_rw), .cmd_pending(cmd_pending),
    .cmd_error(cmd_error), .field_data(field_data), .field_idx(field_idx),
    .o_dbg_state(o_dbg_state)
  );

  // clock / start-pulse monitor
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (m_start[0] === 1'b1) start_cnt0++;
    if (m_start[1] === 1'b1) start_cnt1++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic press_load(input logic [11:0] v);
    switch_array = v;
    load_btn_raw = 1'b0;
    tick(14);
    load_btn_raw = 1'b1;
    tick(14);
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b1; btn_raw = 2'b11; load_btn_raw = 1'b1;
    mode_switch = 1'b0; rw_switch = 2'b00; switch_array = '0; m_busy = 2'b00;
    tick(2);
    checks++;
    if ({m_start, m_rw, cmd_pending, cmd_error} !== 8'h00) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000000", {m_start, m_rw, cmd_pending, cmd_error});
    end
    checks++;
    if (field_data !== 48'h0 || field_idx !== 2'd0) begin
      errors++; $display("FAIL reset_fields: got %h idx %0d expected 0 idx 0", field_data, field_idx);
    end
    checks++;
    if (o_dbg_state !== 6'd0) begin
      errors++; $display("FAIL reset_state: got %h expected 0", o_dbg_state);
    end
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_glitch;
    mode_switch = 1'b1; m_busy = 2'b00;
    base = start_cnt0;
    btn_raw[0] = 1'b0;
    tick(5);
    btn_raw[0] = 1'b1;
    tick(20);
    checks++;
    if (start_cnt0 - base != 0 || cmd_pending !== 2'b00) begin
      errors++; $display("FAIL glitch: starts %0d pending %b expected 0 00", start_cnt0 - base, cmd_pending);
    end
    checks++;
    if (dut.r_db[0] !== 1'b1) begin
      errors++; $display("FAIL glitch_db: got %b expected 1", dut.r_db[0]);
    end
  endtask

  task automatic test_load;
    mode_switch = 1'b0;
    press_load(12'd10);
    press_load(12'h3FF);
    press_load(12'd5);
    checks++;
    if (field_data[35:0] !== {12'd5, 12'h3FF, 12'd10} || field_idx !== 2'd3) begin
      errors++; $display("FAIL load3: got %h idx %0d expected 0053ff00a idx 3", field_data[35:0], field_idx);
    end
    press_load(12'd7);
    checks++;
    if (field_data !== {12'd7, 12'd5, 12'h3FF, 12'd10} || field_idx !== 2'd0) begin
      errors++; $display("FAIL load_wrap: got %h idx %0d expected 0070053ff00a idx 0", field_data, field_idx);
    end
    // trigger press in config mode is ignored
    base = start_cnt0;
    btn_raw[0] = 1'b0; tick(14);
    btn_raw[0] = 1'b1; tick(14);
    checks++;
    if (start_cnt0 - base != 0 || cmd_pending !== 2'b00) begin
      errors++; $display("FAIL cfg_trigger: starts %0d pending %b expected 0 00", start_cnt0 - base, cmd_pending);
    end
    // load press in run mode is ignored
    mode_switch = 1'b1;
    press_load(12'hABC);
    checks++;
    if (field_data !== {12'd7, 12'd5, 12'h3FF, 12'd10} || field_idx !== 2'd0) begin
      errors++; $display("FAIL run_load: got %h idx %0d expected unchanged", field_data, field_idx);
    end
  endtask

  task automatic test_run_ch0;
    logic early;
    early = 1'b0;
    mode_switch = 1'b1; rw_switch = 2'b01; m_busy = 2'b00;
    base = start_cnt0;
    btn_raw[0] = 1'b0;
    for (int e = 0; e <= 10; e++) begin
      tick(1);
      if (m_start[0] !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++; $display("FAIL run_early: m_start seen before edge 11, expected none");
    end
    tick(1);
    checks++;
    if (m_start[0] !== 1'b1 || m_rw[0] !== 1'b1 || cmd_pending[0] !== 1'b1) begin
      errors++; $display("FAIL run_start: start %b rw %b pend %b expected 1 1 1", m_start[0], m_rw[0], cmd_pending[0]);
    end
    tick(1);
    checks++;
    if (m_start[0] !== 1'b0) begin
      errors++; $display("FAIL run_pulse: got %b expected 0", m_start[0]);
    end
    tick(2);
    m_busy[0] = 1'b1;
    tick(20);
    checks++;
    if (cmd_pending[0] !== 1'b1 || o_dbg_state[2:0] !== 3'd4) begin
      errors++; $display("FAIL run_active: pend %b state %0d expected 1 4", cmd_pending[0], o_dbg_state[2:0]);
    end
    m_busy[0] = 1'b0;
    tick(1);
    checks++;
    if (cmd_pending[0] !== 1'b0 || cmd_error[0] !== 1'b0 || start_cnt0 - base != 1) begin
      errors++; $display("FAIL run_done: pend %b err %b starts %0d expected 0 0 1", cmd_pending[0], cmd_error[0], start_cnt0 - base);
    end
    btn_raw[0] = 1'b1;
    tick(15);
  endtask

  task automatic test_pending_ch1;
    rw_switch = 2'b00; m_busy[1] = 1'b1;
    base = start_cnt1;
    btn_raw[1] = 1'b0;
    tick(14);
    checks++;
    if (start_cnt1 - base != 0 || cmd_pending[1] !== 1'b1 || o_dbg_state[5:3] !== 3'd1) begin
      errors++; $display("FAIL pend_wait: starts %0d pend %b state %0d expected 0 1 1", start_cnt1 - base, cmd_pending[1], o_dbg_state[5:3]);
    end
    m_busy[1] = 1'b0;
    tick(1);
    checks++;
    if (m_start[1] !== 1'b1 || m_rw !== 2'b01) begin
      errors++; $display("FAIL pend_start: start %b rw %b expected 1 01", m_start[1], m_rw);
    end
    m_busy[1] = 1'b1;
    tick(3);
    btn_raw[1] = 1'b1; tick(14);
    btn_raw[1] = 1'b0; tick(14);
    btn_raw[1] = 1'b1; tick(14);
    m_busy[1] = 1'b0;
    tick(2);
    checks++;
    if (start_cnt1 - base != 1 || cmd_pending[1] !== 1'b0 || cmd_error[1] !== 1'b0) begin
      errors++; $display("FAIL b2b_drop: starts %0d pend %b err %b expected 1 0 0", start_cnt1 - base, cmd_pending[1], cmd_error[1]);
    end
  endtask

  task automatic test_timeout;
    rw_switch = 2'b00; m_busy = 2'b00;
    btn_raw[0] = 1'b0;
    tick(12);
    tick(16);
    checks++;
    if (cmd_error[0] !== 1'b0 || cmd_pending[0] !== 1'b1) begin
      errors++; $display("FAIL to_early: err %b pend %b expected 0 1", cmd_error[0], cmd_pending[0]);
    end
    tick(1);
    checks++;
    if (cmd_error[0] !== 1'b1 || cmd_pending[0] !== 1'b0 || o_dbg_state[2:0] !== 3'd0) begin
      errors++; $display("FAIL to_err: err %b pend %b state %0d expected 1 0 0", cmd_error[0], cmd_pending[0], o_dbg_state[2:0]);
    end
    btn_raw[0] = 1'b1; tick(15);
    btn_raw[0] = 1'b0;
    tick(12);
    checks++;
    if (cmd_error[0] !== 1'b0 || m_start[0] !== 1'b1) begin
      errors++; $display("FAIL to_clear: err %b start %b expected 0 1", cmd_error[0], m_start[0]);
    end
    m_busy[0] = 1'b1; tick(3);
    m_busy[0] = 1'b0; tick(2);
    btn_raw[0] = 1'b1; tick(15);
  endtask

  task automatic test_enable;
    enable = 1'b0;
    base = start_cnt0;
    btn_raw[0] = 1'b0; tick(14);
    btn_raw[0] = 1'b1; tick(14);
    enable = 1'b1;
    tick(2);
    checks++;
    if (start_cnt0 - base != 0 || cmd_pending[0] !== 1'b0) begin
      errors++; $display("FAIL enable_off: starts %0d pend %b expected 0 0", start_cnt0 - base, cmd_pending[0]);
    end
  endtask

  task automatic test_reset_mid;
    mode_switch = 1'b0;
    press_load(12'h111);
    press_load(12'h222);
    mode_switch = 1'b1; m_busy = 2'b00;
    btn_raw[0] = 1'b0;
    tick(12);
    m_busy[0] = 1'b1;
    tick(3);
    checks++;
    if (cmd_pending[0] !== 1'b1 || field_idx !== 2'd2 || o_dbg_state[2:0] !== 3'd4) begin
      errors++; $display("FAIL mid_pre: pend %b idx %0d state %0d expected 1 2 4", cmd_pending[0], field_idx, o_dbg_state[2:0]);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({m_start, m_rw, cmd_pending, cmd_error} !== 8'h00 || field_data !== 48'h0 || field_idx !== 2'd0) begin
      errors++; $display("FAIL mid_reset: ctrl %b data %h idx %0d expected 0 0 0", {m_start, m_rw, cmd_pending, cmd_error}, field_data, field_idx);
    end
    tick(2);
    rst = 1'b0; m_busy = 2'b00;
    base = start_cnt0;
    tick(25);
    checks++;
    if (start_cnt0 - base != 0 || cmd_pending[0] !== 1'b0) begin
      errors++; $display("FAIL mid_held: starts %0d pend %b expected 0 0", start_cnt0 - base, cmd_pending[0]);
    end
    btn_raw[0] = 1'b1; tick(15);
    btn_raw[0] = 1'b0;
    tick(12);
    checks++;
    if (m_start[0] !== 1'b1) begin
      errors++; $display("FAIL mid_repress: start %b expected 1", m_start[0]);
    end
    m_busy[0] = 1'b1; tick(3);
    m_busy[0] = 1'b0; tick(2);
    btn_raw[0] = 1'b1; tick(15);
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_load();
    test_run_ch0();
    test_pending_ch1();
    test_timeout();
    test_enable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
